hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the five-stage MIPS core.
- Decides each cycle whether the F/D stage registers hold or load, and whether a bubble is injected into E.
- Contains the multiply/divide busy scheduler, which is a cycle counter for HI/LO operations.
- Accepts the exception/interrupt request (req) that overrides stalls and flushes the pipeline.
- Sits beside the F, D and E pipeline registers and drives their write-enable and clear inputs.

---
 rtl/hazard_stall_ctrl_pkg.sv | 10 +
 rtl/md_busy_counter.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 56 +++++
 tb/tb_hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared timing encodings, mult/div latencies and FSM states
package hazard_stall_ctrl_pkg;
    localparam logic [1:0] T_0    = 2'd0;
    localparam logic [1:0] T_1    = 2'd1;
    localparam logic [1:0] T_2    = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: mult/div busy scheduler that holds busy for the operation latency
// Ports: clk, reset (sync, active-high), start (accepted mult/div issue),
//        is_div (1 = div latency), busy (unit occupied)
import hazard_stall_ctrl_pkg::*;

module md_busy_counter #(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    md_state_t state;
    logic [CNT_W-1:0] cnt;

    // A start while BUSY is ignored; leaving at cnt==0 keeps the decrement from wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= BUSY;
                cnt   <= is_div ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
            end
        end else if (cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (state == BUSY);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: F/D hold, E bubble and flush control for the five-stage pipeline
// Ports: D_rs/D_rt/D_tuse_* (D operand needs), D_is_md, E_/M_wreg and tnew (producers),
//        md_start/md_is_div (mult/div issue in E), req (exception), outputs F_we, D_we,
//        E_clr, flush, md_busy
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic       D_is_md,
    input  logic [4:0] E_wreg,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wreg,
    input  logic [1:0] M_tnew,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       req,
    output logic       F_we,
    output logic       D_we,
    output logic       E_clr,
    output logic       flush,
    output logic       md_busy
);
    logic hz_rs, hz_rt, hz_md, stall;

    // A start in a cycle with req belongs to a cancelled instruction
    md_busy_counter #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .start (md_start & ~req),
        .is_div(md_is_div),
        .busy  (md_busy)
    );

    always_comb begin
        hz_rs = (D_rs != 5'd0) && ((D_rs == E_wreg && D_tuse_rs < E_tnew) ||
                                   (D_rs == M_wreg && D_tuse_rs < M_tnew));
        hz_rt = (D_rt != 5'd0) && ((D_rt == E_wreg && D_tuse_rt < E_tnew) ||
                                   (D_rt == M_wreg && D_tuse_rt < M_tnew));
        hz_md = D_is_md & (md_busy | md_start);
        stall = (hz_rs | hz_rt | hz_md) & ~req;
    end

    assign F_we  = ~stall;
    assign D_we  = ~stall;
    assign E_clr = stall;
    assign flush = req;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks against a latency-count model
module tb_hazard_stall_ctrl;
    logic clk = 0, reset = 1;
    logic [4:0] D_rs = 0, D_rt = 0, E_wreg = 0, M_wreg = 0;
    logic [1:0] D_tuse_rs = 3, D_tuse_rt = 3, E_tnew = 0, M_tnew = 0;
    logic D_is_md = 0, md_start = 0, md_is_div = 0, req = 0;
    logic F_we, D_we, E_clr, flush, md_busy;
    int passed = 0, total = 0;
    int rem = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs),
        .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md), .E_wreg(E_wreg), .E_tnew(E_tnew),
        .M_wreg(M_wreg), .M_tnew(M_tnew), .md_start(md_start), .md_is_div(md_is_div),
        .req(req), .F_we(F_we), .D_we(D_we), .E_clr(E_clr), .flush(flush), .md_busy(md_busy)
    );

    function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
        return r != 0 && ((r == E_wreg && tu < E_tnew) || (r == M_wreg && tu < M_tnew));
    endfunction

    function automatic bit exp_stall();
        return (hz(D_rs, D_tuse_rs) || hz(D_rt, D_tuse_rt) ||
                (D_is_md && (rem > 0 || md_start))) && !req;
    endfunction

    // Model: remaining busy cycles; each edge consumes one, a new op loads its latency
    task automatic tick();
        int nxt;
        if (reset) nxt = 0;
        else if (rem > 0) nxt = rem - 1;
        else if (md_start && !req) nxt = md_is_div ? 10 : 5;
        else nxt = 0;
        @(posedge clk);
        #1;
        rem = nxt;
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_is_md = 0;
        E_wreg = 0; E_tnew = 0; M_wreg = 0; M_tnew = 0;
        md_start = 0; md_is_div = 0; req = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0; #1;
        total++;
        if ({md_busy, F_we, D_we, E_clr, flush} !== 5'b01100)
            $display("FAIL reset: busy/F_we/D_we/E_clr/flush=%b want 01100",
                     {md_busy, F_we, D_we, E_clr, flush});
        else passed++;
    endtask

    task automatic test_load_use();
        D_rs = 5; D_tuse_rs = 0; E_wreg = 5; E_tnew = 2; #1;
        total++;
        if ({F_we, D_we, E_clr} !== 3'b001) $display("FAIL load_use_e: got %b want 001", {F_we, D_we, E_clr});
        else passed++;
        tick();
        E_wreg = 0; M_wreg = 5; M_tnew = 1; #1;
        total++;
        if ({F_we, D_we, E_clr} !== 3'b001) $display("FAIL load_use_m: got %b want 001", {F_we, D_we, E_clr});
        else passed++;
        tick();
        M_tnew = 0; #1;
        total++;
        if ({F_we, D_we, E_clr} !== 3'b110) $display("FAIL load_use_clear: got %b want 110", {F_we, D_we, E_clr});
        else passed++;
        D_rt = 7; D_tuse_rt = 1; E_wreg = 7; E_tnew = 2; #1;
        total++;
        if (E_clr !== 1'b1) $display("FAIL rt_hazard: E_clr=%b want 1", E_clr);
        else passed++;
        tick(); idle_inputs();
    endtask

    task automatic test_zero_reg();
        D_rs = 0; E_wreg = 0; E_tnew = 2; D_tuse_rs = 0; M_wreg = 0; M_tnew = 2; #1;
        total++;
        if ({F_we, E_clr} !== 2'b10) $display("FAIL zero_reg: F_we/E_clr=%b want 10", {F_we, E_clr});
        else passed++;
        tick(); idle_inputs();
    endtask

    task automatic test_mult();
        int busy_cnt = 0, stall_cnt = 0;
        D_is_md = 1; md_start = 1; md_is_div = 0; #1;
        if (E_clr) stall_cnt++;
        tick();
        md_start = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (md_busy) busy_cnt++;
            if (E_clr) stall_cnt++;
            tick();
        end
        total++;
        if (busy_cnt !== 5) $display("FAIL mult_busy_len: %0d cycles want 5", busy_cnt);
        else passed++;
        total++;
        if (stall_cnt !== 6) $display("FAIL mult_stall_len: %0d cycles want 6", stall_cnt);
        else passed++;
        #1;
        total++;
        if (D_we !== 1'b1) $display("FAIL mult_release: D_we=%b want 1", D_we);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_div();
        int busy_cnt = 0, stall_cnt = 0;
        md_start = 1; md_is_div = 1; D_rs = 3; D_tuse_rs = 0; E_wreg = 4; E_tnew = 2; #1;
        tick();
        md_start = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (md_busy) busy_cnt++;
            if (E_clr) stall_cnt++;
            tick();
        end
        total++;
        if (busy_cnt !== 10) $display("FAIL div_busy_len: %0d cycles want 10", busy_cnt);
        else passed++;
        total++;
        if (stall_cnt !== 0) $display("FAIL div_non_md_stall: %0d stalls want 0", stall_cnt);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_req();
        D_rs = 9; D_tuse_rs = 0; E_wreg = 9; E_tnew = 1; req = 1; #1;
        total++;
        if ({F_we, D_we, E_clr, flush} !== 4'b1101)
            $display("FAIL req_priority: got %b want 1101", {F_we, D_we, E_clr, flush});
        else passed++;
        idle_inputs();
        req = 1; md_start = 1; md_is_div = 1;
        tick();
        md_start = 0; req = 0; #1;
        total++;
        if (md_busy !== 1'b0) $display("FAIL req_cancel_start: md_busy=%b want 0", md_busy);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        md_start = 1; md_is_div = 1;
        tick();
        md_start = 0;
        tick(); tick();
        #1;
        total++;
        if (md_busy !== 1'b1) $display("FAIL reset_mid_pre: md_busy=%b want 1", md_busy);
        else passed++;
        reset = 1;
        tick();
        reset = 0; D_is_md = 1; #1;
        total++;
        if ({md_busy, D_we} !== 2'b01) $display("FAIL reset_mid: busy/D_we=%b want 01", {md_busy, D_we});
        else passed++;
        tick(); idle_inputs();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            E_wreg = 5'($urandom_range(0, 3)); M_wreg = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom); D_tuse_rt = 2'($urandom);
            E_tnew = 2'($urandom); M_tnew = 2'($urandom);
            D_is_md = 1'($urandom); md_start = ($urandom_range(0, 5) == 0);
            md_is_div = 1'($urandom); req = ($urandom_range(0, 7) == 0);
            #1;
            total++;
            if ({md_busy, F_we, D_we, E_clr, flush} !== {rem > 0, !exp_stall(), !exp_stall(), exp_stall(), req}) begin
                if (bad < 10)
                    $display("FAIL random[%0d]: busy/F_we/D_we/E_clr/flush=%b want %b", i,
                             {md_busy, F_we, D_we, E_clr, flush},
                             {rem > 0, !exp_stall(), !exp_stall(), exp_stall(), req});
                bad++;
            end else passed++;
            tick();
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mult();
        test_div();
        test_req();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
